// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller driving the b side of an external magnitude comparator.
// Define SAR_FLAG_CHECK_EN to abort on comparator flag sets that are not one-hot.
module sar_search_ctrl #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  input  logic                  cmp_g_in,
  input  logic                  cmp_e_in,
  input  logic                  cmp_l_in,
  output logic [DATA_WIDTH-1:0] trial_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  found_out,
  output logic                  fault_out
);

  localparam int KW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

`ifdef SAR_FLAG_CHECK_EN
  localparam bit FlagCheckEn = 1'b1;
`else
  localparam bit FlagCheckEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FLAG_E    = 2'd0,
    FLAG_G    = 2'd1,
    FLAG_L    = 2'd2,
    FLAG_NONE = 2'd3
  } flag_e;

  state_e                state_q;
  logic [KW-1:0]         k_q;
  logic [DATA_WIDTH-1:0] trial_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  found_q;
  logic                  fault_q;

  flag_e                 flag_d;
  logic                  abort_d;
  logic [DATA_WIDTH-1:0] bit_mask_d;
  logic [DATA_WIDTH-1:0] trial_d;

  // NOTE: every output of a combinational block gets a default first, so no path can leave a latch.
  always_comb begin
    flag_d     = FLAG_NONE;
    abort_d    = 1'b0;
    bit_mask_d = DATA_WIDTH'(1) << k_q;
    trial_d    = trial_q;

    if (cmp_e_in)      flag_d = FLAG_E;
    else if (cmp_g_in) flag_d = FLAG_G;
    else if (cmp_l_in) flag_d = FLAG_L;

    // One-hot of three bits: odd parity and not all three set.
    abort_d = FlagCheckEn &&
              (!(cmp_g_in ^ cmp_e_in ^ cmp_l_in) || (cmp_g_in && cmp_e_in && cmp_l_in));

    // Greater keeps bit k, anything else (less or no flag) clears it; then try bit k-1.
    // At k == 0 the shifted mask is zero, so this also covers the last SEARCH step.
    trial_d = ((flag_d == FLAG_G) ? trial_q : (trial_q & ~bit_mask_d)) | (bit_mask_d >> 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      trial_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_in) begin
            trial_q <= DATA_WIDTH'(1) << (DATA_WIDTH - 1);
            k_q     <= KW'(DATA_WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= ST_SEARCH;
          end
        end

        ST_SEARCH: begin
          if (abort_d || flag_d == FLAG_E) begin
            result_q <= trial_q;
            found_q  <= !abort_d;
            fault_q  <= abort_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            trial_q <= trial_d;
            if (k_q == '0) state_q <= ST_CHECK;
            else           k_q     <= k_q - KW'(1);
          end
        end

        ST_CHECK: begin
          result_q <= trial_q;
          found_q  <= cmp_e_in && !abort_d;
          fault_q  <= abort_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign trial_out  = trial_q;
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign result_out = result_q;
  assign found_out  = found_q;
  assign fault_out  = fault_q;

endmodule

// File: doc/sar_search_ctrl.md
# sar_search_ctrl

Successive-approximation search controller that sits on the b side of an external magnitude comparator. It drives trial values and reads back the comparator's greater/equal/less flags to recover an unknown DATA_WIDTH-bit target. It then reports the recovered value with a one-cycle done pulse. The result is found in at most DATA_WIDTH+1 compare cycles.

## Interface
- DATA_WIDTH, 4: width of the target, the trial and the result.
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- start_in  input  1  request a search; sampled only in IDLE.
- cmp_g_in  input  1  target > trial_out (from the external comparator).
- cmp_e_in  input  1  target == trial_out.
- cmp_l_in  input  1  target < trial_out.
- trial_out  output  DATA_WIDTH  registered trial value driven to the comparator's b side.
- busy_out  output  1  high in SEARCH and CHECK.
- done_out  output  1  one-cycle pulse when the result is valid.
- result_out  output  DATA_WIDTH  recovered value; holds until the next done.
- found_out  output  1  the result was confirmed equal; holds until the next done.
- fault_out  output  1  illegal flag combination seen; holds until the next done.

## Operation
- States: IDLE, SEARCH, CHECK. A 2-bit state register plus a bit index.
- IDLE + start_in:
  - load trial_out = 1 << (DATA_WIDTH-1);
  - set bit index k = DATA_WIDTH-1;
  - go to SEARCH.
- SEARCH, each edge, flags sampled against the current trial_out:
  - e: result_out = trial_out, found_out = 1, pulse done_out, go to IDLE.
  - g, k > 0: keep bit k, set bit k-1, k = k-1.
  - l, k > 0: clear bit k, set bit k-1, k = k-1.
  - k == 0, g: trial unchanged, go to CHECK.
  - k == 0, l: clear bit 0, go to CHECK.
- CHECK, one edge:
  - result_out = trial_out, found_out = cmp_e_in, pulse done_out, go to IDLE.
  - found_out = 0 here means the target was inconsistent or changed during the search.
- Flag priority: e > g > l. With no flag asserted, the controller treats it as l.
- start_in during SEARCH or CHECK is ignored and is not queued.
- start_in in the IDLE cycle where done_out is high is accepted.
- trial_out holds its last value in IDLE.
- Arithmetic: bit set/clear only; there is no add/subtract, so there is no wrap-around.

## Timing
- Reset values:
  - state IDLE, trial_out 0, busy_out 0, done_out 0;
  - result_out 0, found_out 0, fault_out 0.
- Reset asserted mid-search forces all reset values immediately and abandons the search. No done pulse is produced.
- The comparator is combinational on trial_out, so the flags are valid in the same cycle and are sampled at the next edge.
- start sampled at edge 0 → first trial presented in cycle 1 and sampled at edge 1.
- Equality at the k-th trial (edge k) → done_out high in cycle k+1 and busy_out low in the same cycle.
- Worst case: DATA_WIDTH SEARCH edges + 1 CHECK edge. done_out is high in cycle DATA_WIDTH+2.
- result_out, found_out and fault_out are updated on the same edge that raises done_out.

## Configuration
- Macro: SAR_FLAG_CHECK_EN.
- When defined:
  - in SEARCH and CHECK, a flag set that is not exactly one-hot (none asserted, or two or more asserted) aborts the search;
  - on abort: done_out pulses, found_out = 0, fault_out = 1, result_out = current trial_out, go to IDLE.
- When undefined:
  - fault_out is tied to 0;
  - the priority rule (e > g > l, none treated as l) applies.

## Test plan
- Target 11, DATA_WIDTH 4 → trials 8, 12, 10, 11; done in cycle 5 after start; result 11, found 1.
- Target 0 → trials 8, 4, 2, 1, then CHECK with trial 0; done in cycle 6; result 0, found 1.
- Target 8 → equality on the first trial; done in cycle 2; result 8, found 1. Start pulsed during the done cycle begins a new search with trial 8.
- Reset driven low during the 2nd trial → all outputs go to 0 immediately and no done pulse follows. start_in pulsed while busy has no effect.
- Target changed from 5 to 9 after the 2nd trial → search ends in CHECK with found 0 and done still pulsed.
- SAR_FLAG_CHECK_EN defined, g and l both forced high on the 1st trial → done in cycle 2, fault 1, found 0, result 8. With the macro undefined, the same stimulus is treated as g and the search continues.
